// File: rtl/ling_serial_subtractor.sv
// ling_serial_subtractor
// Multi-precision unsigned subtractor, D = A - B, one byte per beat, LSB first.
// Each beat runs an 8-bit sparse-4 Ling sum slice computing a + ~b + c_in; the
// carry-out is kept as the inverted borrow for the next byte of the operand.
// The final beat of each operand also reports the borrow (A < B) and a zero flag (A == B).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_a/in_b are the minuend/subtrahend bytes
//   out_valid/out_ready   output handshake; single registered output stage
//   out_diff              difference byte
//   out_last              beat is byte WORDS-1 of the operand
//   out_borrow, out_zero  operand flags, meaningful only with out_last (0 otherwise)
//
// state | meaning
// FIRST | expecting byte 0 of an operand; carry-in forced to 1 (no borrow)
// MID   | inside an operand; carry-in taken from the carry register
module ling_serial_subtractor #(
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_diff,
  output logic       out_last,
  output logic       out_borrow,
  output logic       out_zero
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic {FIRST, MID} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          zacc;

  logic       in_fire;
  logic       is_last;
  logic       cin;
  logic [7:0] bn, g, p, x;
  logic       g10, p10, g54, p54;
  logic       h3, h7;
  logic [8:0] c;
  logic [7:0] diff;
  logic       nz;

  assign in_ready = ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign is_last  = (cnt == LAST_IDX);
  assign cin      = (state == FIRST) ? 1'b1 : carry;

  // Bitwise generate / propagate / half-sum against the inverted subtrahend.
  assign bn = ~in_b;
  assign g  = in_a & bn;
  assign p  = in_a | bn;
  assign x  = in_a ^ bn;

  // Pair-wise group terms.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];

  // Ling pseudo-carries at bits 3 and 7; the real carry is p & h, and the
  // group carry-in (cin, then c[4]) is folded into the group term.
  assign h3 = g[3] | g[2] | (p[2] & (g10 | (p10 & cin)));
  assign c[4] = p[3] & h3;
  assign h7 = g[7] | g[6] | (p[6] & (g54 | (p54 & c[4])));
  assign c[8] = p[7] & h7;

  // Intra-nibble carries rippled from each sparse carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g10 | (p10 & cin);
  assign c[3] = g[2] | (p[2] & c[2]);
  assign c[5] = g[4] | (p[4] & c[4]);
  assign c[6] = g54 | (p54 & c[4]);
  assign c[7] = g[6] | (p[6] & c[6]);

  assign diff = x ^ c[7:0];
  assign nz   = |diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FIRST;
      cnt        <= '0;
      carry      <= 1'b0;
      zacc       <= 1'b0;
      out_valid  <= 1'b0;
      out_diff   <= 8'h00;
      out_last   <= 1'b0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_diff  <= diff;
      out_last  <= is_last;
      carry     <= c[8];
      if (is_last) begin
        state      <= FIRST;
        cnt        <= '0;
        out_borrow <= ~c[8];
        out_zero   <= ~(zacc | nz);
        zacc       <= 1'b0;
      end else begin
        state      <= MID;
        cnt        <= cnt + CW'(1);
        out_borrow <= 1'b0;
        out_zero   <= 1'b0;
        zacc       <= zacc | nz;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
